// File: rtl/bs4_shift_seq.sv
// Iterative 4-bit shift/rotate sequencer driving the barrel-shifter 2:1 mux stage one bit per cycle.
// Optional feature: define BS4_ROTATE_EN to honour in_rot; otherwise every request is a logical shift.
module bs4_shift_seq #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic             in_rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_r;
    logic [AMT_W-1:0] cnt;
    logic             dir_r;
    logic             rot_r;
    logic             rot_in;
    logic             accept;
    logic             mux_sel;
    logic [WIDTH-1:0] step_y;
    logic [WIDTH-1:0] mux_y;

`ifdef BS4_ROTATE_EN
    assign rot_in = in_rot;
`else
    logic unused_rot;
    assign unused_rot = in_rot;
    assign rot_in     = 1'b0;
`endif

    // One-bit step: the vacated position is filled with zero or, when rotating, the bit shifted out.
    function automatic logic [3:0] step_fn(input logic [3:0] d, input logic dir, input logic rot);
        logic fill;
        if (!dir) begin
            fill    = rot ? d[3] : 1'b0;
            step_fn = {d[2:0], fill};
        end else begin
            fill    = rot ? d[0] : 1'b0;
            step_fn = {fill, d[3:1]};
        end
    endfunction

    assign accept  = in_valid && in_ready;
    assign mux_sel = (state_q == S_SHIFT);
    assign step_y  = step_fn(data_r, dir_r, rot_r);
    assign mux_y   = mux_sel ? step_y : data_r;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (in_amt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt == AMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working register sits on the mux output; a new operand overrides it only at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= '0;
            cnt    <= '0;
            dir_r  <= 1'b0;
            rot_r  <= 1'b0;
        end else if (accept) begin
            data_r <= in_data;
            cnt    <= in_amt;
            dir_r  <= in_dir;
            rot_r  <= rot_in;
        end else begin
            data_r <= mux_y;
            if (mux_sel) begin
                cnt <= cnt - AMT_W'(1);
            end
        end
    end

    assign out_data = data_r;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: doc/bs4_shift_seq.md
# bs4_shift_seq

Iterative 4-bit shift/rotate sequencer that sits directly around the 4-bit 2:1 mux stage of the barrel-shifter datapath. It accepts an operand and shift amount over a valid/ready handshake and drives the mux select once per cycle, one bit position per step. It registers the mux output back into its working register and presents the final result over a second valid/ready handshake.

## Interface
- WIDTH, 4, operand width; only 4 is supported.
- AMT_W, 2, shift-amount width (0..3).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when high with in_valid
- in_data  in  4  operand
- in_amt  in  2  shift amount, 0..3
- in_dir  in  1  0 = left (toward MSB), 1 = right
- in_rot  in  1  1 = rotate, 0 = logical shift (zero fill)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  4  result; holds the working register
- busy  out  1  high in SHIFT or DONE

## Operation
The block runs a three-state FSM.

- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load data_r<=in_data, cnt<=in_amt, and latch dir_r and rot_r.
  - Next state is DONE if in_amt==0, else SHIFT.
- SHIFT:
  - in_ready=0.
  - Mux select=1 each cycle, so data_r<=step(data_r) and cnt<=cnt-1.
  - Go to DONE when cnt==1 at the clock edge.
- DONE:
  - out_valid=1 and in_ready=0.
  - On out_ready: go to IDLE. Otherwise hold data_r and out_valid.

Step function (one bit):
- Left: {d[2:0], fill}, with fill = rot_r ? d[3] : 0.
- Right: {fill, d[3:1]}, with fill = rot_r ? d[0] : 0.

Datapath and handshake rules:
- The hold/step choice is made by the codebase's 4-bit 2:1 mux stage. a=data_r, b=step(data_r), s=(state==SHIFT).
- Input fields are sampled only at acceptance. Later changes to in_* have no effect.
- in_valid in SHIFT or DONE is ignored. No request is lost or queued; the upstream must hold it.
- The number of steps applied is always exactly in_amt. There is no wrap-around of cnt.

## Timing
- Reset values (first cycle after a rst edge): state=IDLE, in_ready=1, out_valid=0, out_data=4'b0000, busy=0, cnt=0.
- rst asserted mid-operation abandons the operation. No out_valid is produced for it.
- rst has priority over every handshake in the same cycle.
- Latency: if accepted at edge E0, out_valid rises after edge E0+in_amt.
  - amt=0: out_valid in the cycle after acceptance.
  - amt=3: out_valid three edges later.
- out_data is stable and equal to the final result for every cycle out_valid=1.
- The result transfer completes on the edge where out_valid&out_ready.
- in_ready rises the cycle after the result transfer. Back-to-back spacing is amt+2 cycles minimum.
- out_ready high before DONE has no effect.
- busy = (state!=IDLE). It is combinational from state and registered-clean.

## Configuration
- Macro: BS4_ROTATE_EN.
- Defined: in_rot is honoured and rotate fill is wrapped as in the step function.
- Undefined: rot_r is forced to 0. in_rot is ignored, and every request is a logical shift with zero fill. Port list is unchanged.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, out_data=0000, busy=0.
- in_data=1011, amt=2, dir=0, rot=0 -> out_valid 2 edges after acceptance, out_data=1100.
- With BS4_ROTATE_EN: in_data=1011, amt=3, dir=1, rot=1 -> out_data=0111.
  - Without the macro, the same request gives 0001.
- amt=0, in_data=0110 -> out_valid the cycle after acceptance, out_data=0110.
- Result held with out_ready=0 for 5 cycles, in_valid kept high with a new operand:
  - out_data is unchanged, in_ready=0, no second accept.
  - After out_ready=1, the new request is accepted one cycle later.
- rst pulsed during SHIFT of amt=3:
  - Next cycle shows the reset values.
  - No out_valid is produced for the aborted request.
